// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multicycle signed multiply/divide unit with internal HI/LO result
// registers, used for the MIPS MULT/DIV/MFHI/MFLO instructions.
//
// A multiply runs as radix-2 Booth recoding, one step per cycle. A divide
// runs as unsigned restoring division on the operand magnitudes, then
// one cycle that fixes up the result signs. A divide by zero finishes at
// once, leaves HI/LO untouched and flags div_zero.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start_mult  1-cycle request: signed w_a * w_b (wins over start_div)
//   start_div   1-cycle request: signed w_a / w_b
//   w_a, w_b    operands, captured only when a start is accepted in IDLE
//   w_hi        HI register: product upper half, or remainder
//   w_lo        LO register: product lower half, or quotient
//   busy        high while in MULT, DIV or FIX
//   done        1-cycle pulse, HI/LO valid from this cycle on
//   div_zero    1-cycle pulse alongside done when the divisor was zero

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    output logic [WIDTH-1:0] w_hi,
    output logic [WIDTH-1:0] w_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    // Two's-complement magnitude; the most negative value maps to itself,
    // which still reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return ZERO_W - v;
        end else begin
            return v;
        end
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        if (neg) begin
            return ZERO_W - v;
        end else begin
            return v;
        end
    endfunction

    state_t             state_r, state_s;

    // Booth accumulator: {upper partial product (WIDTH+1), multiplier (WIDTH)}.
    // The extra upper bit keeps the most negative multiplicand exact.
    logic [2*WIDTH:0]   acc_r, acc_s, acc_step_s;
    logic [WIDTH:0]     mcand_r, mcand_s;
    logic [WIDTH:0]     booth_upper_s, booth_sum_s;
    logic               booth_r, booth_s;

    // Restoring divider: partial remainder, quotient/dividend shift register,
    // divisor magnitude and the sign corrections applied in FIX.
    logic [WIDTH-1:0]   rem_r, rem_s, rem_step_s;
    logic [WIDTH-1:0]   quo_r, quo_s, quo_step_s;
    logic [WIDTH-1:0]   dvs_r, dvs_s;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
    logic               neg_quo_r, neg_quo_s;
    logic               neg_rem_r, neg_rem_s;

    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               div_zero_r, div_zero_s;

    // One Booth step: add/subtract multiplicand per the recoded bit pair,
    // then arithmetic shift right of the whole accumulator.
    always_comb begin
        booth_upper_s = acc_r[2*WIDTH:WIDTH];
        booth_sum_s   = booth_upper_s;
        case ({acc_r[0], booth_r})
            2'b01:   booth_sum_s = booth_upper_s + mcand_r;
            2'b10:   booth_sum_s = booth_upper_s - mcand_r;
            default: booth_sum_s = booth_upper_s;
        endcase
        acc_step_s = {booth_sum_s[WIDTH], booth_sum_s, acc_r[WIDTH-1:1]};
    end

    // One restoring-division step: shift in the next dividend bit and keep
    // the difference only when it does not go negative.
    always_comb begin
        div_shift_s = {rem_r, quo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, dvs_r};
        if (!div_diff_s[WIDTH]) begin
            rem_step_s = div_diff_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = div_shift_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-register logic for the control FSM and datapath.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        booth_s    = booth_r;
        mcand_s    = mcand_r;
        rem_s      = rem_r;
        quo_s      = quo_r;
        dvs_s      = dvs_r;
        neg_quo_s  = neg_quo_r;
        neg_rem_s  = neg_rem_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        div_zero_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_mult) begin
                    mcand_s = {w_a[WIDTH-1], w_a};
                    acc_s   = {{(WIDTH + 1){1'b0}}, w_b};
                    booth_s = 1'b0;
                    cnt_s   = CNT_ZERO;
                    busy_s  = 1'b1;
                    state_s = ST_MULT;
                end else if (start_div) begin
                    if (w_b != ZERO_W) begin
                        rem_s     = ZERO_W;
                        quo_s     = magnitude(w_a);
                        dvs_s     = magnitude(w_b);
                        neg_quo_s = w_a[WIDTH-1] ^ w_b[WIDTH-1];
                        neg_rem_s = w_a[WIDTH-1];
                        cnt_s     = CNT_ZERO;
                        busy_s    = 1'b1;
                        state_s   = ST_DIV;
                    end else begin
                        // Nothing to compute: report and leave HI/LO alone.
                        done_s     = 1'b1;
                        div_zero_s = 1'b1;
                        state_s    = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_MULT: begin
                acc_s   = acc_step_s;
                booth_s = acc_r[0];
                cnt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    // Sign-extension bit above the product is dropped.
                    hi_s    = acc_step_s[2*WIDTH-1:WIDTH];
                    lo_s    = acc_step_s[WIDTH-1:0];
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    busy_s = 1'b1;
                end
            end

            ST_DIV: begin
                rem_s  = rem_step_s;
                quo_s  = quo_step_s;
                cnt_s  = cnt_r + CNT_ONE;
                busy_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_DIV;
                end
            end

            ST_FIX: begin
                lo_s    = negate_if(quo_r, neg_quo_r);
                hi_s    = negate_if(rem_r, neg_rem_r);
                done_s  = 1'b1;
                state_s = ST_DONE;
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= {(2 * WIDTH + 1){1'b0}};
            booth_r    <= 1'b0;
            mcand_r    <= {(WIDTH + 1){1'b0}};
            rem_r      <= ZERO_W;
            quo_r      <= ZERO_W;
            dvs_r      <= ZERO_W;
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            cnt_r      <= CNT_ZERO;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            booth_r    <= booth_s;
            mcand_r    <= mcand_s;
            rem_r      <= rem_s;
            quo_r      <= quo_s;
            dvs_r      <= dvs_s;
            neg_quo_r  <= neg_quo_s;
            neg_rem_r  <= neg_rem_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            div_zero_r <= div_zero_s;
        end
    end

    assign w_hi     = hi_r;
    assign w_lo     = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule
